// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier.
// The master side produces operands and consumes the product; the slave is the multiplier.
interface seq_multiplier_if #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [A_WIDTH-1:0]         a;
  logic [B_WIDTH-1:0]         b;
  logic                       out_valid;
  logic                       out_ready;
  logic [A_WIDTH+B_WIDTH-1:0] product;
  logic                       busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier with valid/ready on both sides.
// One operation in flight; fixed latency of B_WIDTH iterations; full-width product.
// In signed mode the magnitudes are multiplied and the result is negated on entry to DONE.
module seq_multiplier #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int SIGNED  = 0
) (
  input logic             clk,
  input logic             rst_n,
  seq_multiplier_if.slave mul_if
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int C_WIDTH = $clog2(B_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [C_WIDTH-1:0]   cnt_q, cnt_d;
  logic [P_WIDTH-1:0]   acc_q, acc_d;
  logic [P_WIDTH-1:0]   mcand_q, mcand_d;
  logic [B_WIDTH-1:0]   mplier_q, mplier_d;
  logic                 sign_q, sign_d;

  logic [A_WIDTH-1:0]   a_mag;
  logic [B_WIDTH-1:0]   b_mag;
  logic                 sign_in;
  logic [P_WIDTH-1:0]   sum;

  // Operand conditioning: magnitudes and result sign in signed mode, pass-through otherwise.
  // Magnitudes are unsigned A_WIDTH/B_WIDTH values, so the most negative input maps exactly.
  generate
    if (SIGNED != 0) begin : g_signed
      assign a_mag   = mul_if.a[A_WIDTH-1] ? (~mul_if.a + A_WIDTH'(1)) : mul_if.a;
      assign b_mag   = mul_if.b[B_WIDTH-1] ? (~mul_if.b + B_WIDTH'(1)) : mul_if.b;
      assign sign_in = mul_if.a[A_WIDTH-1] ^ mul_if.b[B_WIDTH-1];
    end else begin : g_unsigned
      assign a_mag   = mul_if.a;
      assign b_mag   = mul_if.b;
      assign sign_in = 1'b0;
    end
  endgenerate

  // State and datapath registers.
  // NOTE: every register, datapath included, has a defined reset value so that a reset
  // mid-operation leaves nothing behind that could surface as a stale product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
    end
  end

  // Next-state and datapath update: capture in IDLE, one shift-add step per BUSY cycle,
  // hold in DONE until the consumer takes the product.
  always_comb begin
    // NOTE: hold-by-default assignments first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      IDLE: begin
        if (mul_if.in_valid) begin
          mcand_d  = P_WIDTH'(a_mag);
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = C_WIDTH'(B_WIDTH);
          sign_d   = sign_in;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - C_WIDTH'(1);
        if (cnt_q == C_WIDTH'(1)) begin
          state_d = DONE;
          // Two's complement of zero is zero, so a zero product never turns nonzero here.
          if (sign_q) acc_d = ~sum + P_WIDTH'(1);
        end
      end
      DONE: begin
        if (mul_if.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the registered state; product is the accumulator.
  assign mul_if.in_ready  = (state_q == IDLE);
  assign mul_if.out_valid = (state_q == DONE);
  assign mul_if.busy      = (state_q != IDLE);
  assign mul_if.product   = acc_q;

endmodule
